add3_rr_sched: RTL and testbench

ADD3_RR_SCHED -- requirements
Module: add3_rr_sched

---
 rtl/add3_rr_sched.sv | 149 ++++++++++++++
 tb/tb_add3_rr_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/add3_rr_sched.sv
// add3_rr_sched: four requesters share one two-stage a+b+c adder pipeline.
// A round-robin arbiter picks one requester per cycle. The whole pipeline
// stalls together whenever the output holds an unconsumed response.
module add3_rr_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [39:0] req_a,
    input  logic [39:0] req_b,
    input  logic [39:0] req_c,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic [11:0] rsp_sum,
    input  logic        rsp_ready,
    output logic        busy
);

    // Per-requester operand views
    logic [9:0] a_arr [4];
    logic [9:0] b_arr [4];
    logic [9:0] c_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[10*gi +: 10];
            assign b_arr[gi] = req_b[10*gi +: 10];
            assign c_arr[gi] = req_c[10*gi +: 10];
        end
    endgenerate

    // Arbiter pointer and pipeline state
    logic [1:0]  ptr_q,       ptr_d;
    logic        s1_valid_q,  s1_valid_d;
    logic [10:0] s1_ab_q,     s1_ab_d;
    logic [9:0]  s1_c_q,      s1_c_d;
    logic [1:0]  s1_id_q,     s1_id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [11:0] rsp_sum_q,   rsp_sum_d;
    logic [1:0]  rsp_id_q,    rsp_id_d;

    // Arbitration results
    logic        adv;
    logic        gnt_any;
    logic [1:0]  gnt_idx;
    logic        accept;
    logic [9:0]  sel_a;
    logic [9:0]  sel_b;
    logic [9:0]  sel_c;

    // The pipeline moves only when the output slot is free or being drained.
    assign adv = !rsp_valid_q || rsp_ready;

    // Round-robin search starting at ptr; the first requesting index wins.
    always_comb begin
        logic [1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    // A grant is only offered when the pipeline can take it and reset is
    // released, so req_ready is one-hot or zero and never asserted in reset.
    always_comb begin
        accept    = adv && gnt_any && rst_n;
        req_ready = 4'b0000;
        if (accept) begin
            req_ready = 4'b0001 << gnt_idx;
        end
    end

    // Steer the granted requester's operands into stage 1.
    always_comb begin
        sel_a = a_arr[gnt_idx];
        sel_b = b_arr[gnt_idx];
        sel_c = c_arr[gnt_idx];
    end

    // Pointer moves past the winner only on a real handshake.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt_idx + 2'd1;
        end
    end

    // Stage 1: partial sum a+b, carry c and the owner id forward.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ab_d    = s1_ab_q;
        s1_c_d     = s1_c_q;
        s1_id_d    = s1_id_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_ab_d    = {1'b0, sel_a} + {1'b0, sel_b};
            s1_c_d     = sel_c;
            s1_id_d    = gnt_idx;
        end
    end

    // Stage 2: final sum; a bubble in stage 1 becomes rsp_valid=0.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        if (adv) begin
            rsp_valid_d = s1_valid_q;
            rsp_sum_d   = {1'b0, s1_ab_q} + {2'b00, s1_c_q};
            rsp_id_d    = s1_id_q;
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            s1_valid_q  <= 1'b0;
            s1_ab_q     <= 11'd0;
            s1_c_q      <= 10'd0;
            s1_id_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= 12'd0;
            rsp_id_q    <= 2'd0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_ab_q     <= s1_ab_d;
            s1_c_q      <= s1_c_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = s1_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_add3_rr_sched.sv
// Directed bench for add3_rr_sched: stimulus pushes hand-computed responses
// into a queue; a monitor pops and compares each consumed response.
module tb_add3_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [39:0] req_a, req_b, req_c;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_sum;
    logic        rsp_ready;
    logic        busy;

    logic [9:0]  op_a [4];
    logic [9:0]  op_b [4];
    logic [9:0]  op_c [4];

    logic [13:0] exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    add3_rr_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[10*i +: 10] = op_a[i];
            req_b[10*i +: 10] = op_b[i];
            req_c[10*i +: 10] = op_c[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle: check the grant, record the expected response.
    task automatic step(input logic [3:0] exp_rdy, input int sum, input bit push);
        logic [1:0] id;
        @(negedge clk);
        check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        id = 2'd0;
        for (int i = 0; i < 4; i++) if (exp_rdy[i]) id = 2'(i);
        if (push && exp_rdy != 4'b0000) exp_q.push_back({id, sum[11:0]});
        $display("req grant=%b expect_sum=%0d", exp_rdy, sum);
        tick();
    endtask

    task automatic set_op(input int i, input int a, input int b, input int c);
        op_a[i] = 10'(a);
        op_b[i] = 10'(b);
        op_c[i] = 10'(c);
    endtask

    // Monitor: every consumed response must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            logic [13:0] e;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_rsp: got id=%0d sum=%0d, expected none", rsp_id, rsp_sum);
            end else begin
                e = exp_q.pop_front();
                $display("rsp id=%0d sum=%0d (exp id=%0d sum=%0d)", rsp_id, rsp_sum, e[13:12], e[11:0]);
                check("rsp_id", {30'd0, rsp_id}, {30'd0, e[13:12]});
                check("rsp_sum", {20'd0, rsp_sum}, {20'd0, e[11:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_op(i, 7, 7, 7);

        // Reset state, with all requesters asking
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_sum", {20'd0, rsp_sum}, 32'd0);
        check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        tick();
        req_valid = 4'b0000;
        rst_n = 1'b1;
        tick();

        // Single op at maximum operands, latency 2
        set_op(0, 1023, 1023, 1023);
        req_valid = 4'b0001;
        step(4'b0001, 3069, 1'b1);
        req_valid = 4'b0000;
        @(negedge clk);
        check("lat_n1_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("lat_n2_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        @(negedge clk);
        check("lat_n3_valid", {31'd0, rsp_valid}, 32'd0);
        tick();

        // Fairness from a fresh reset
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, i, 10, 100);
        req_valid = 4'b1111;
        step(4'b0001, 110, 1'b1);
        step(4'b0010, 111, 1'b1);
        step(4'b0100, 112, 1'b1);
        step(4'b1000, 113, 1'b1);
        step(4'b0001, 110, 1'b1);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Rotation: grant 1 moves ptr to 2, so 3 wins over 0
        req_valid = 4'b0010;
        step(4'b0010, 111, 1'b1);
        req_valid = 4'b1001;
        step(4'b1000, 113, 1'b1);
        req_valid = 4'b0001;
        step(4'b0001, 110, 1'b1);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Backpressure: ptr=1, order 1,2 then stall with 0 waiting
        set_op(0, 1, 2, 3);
        set_op(1, 500, 600, 700);
        set_op(2, 1000, 1000, 7);
        req_valid = 4'b0111;
        step(4'b0010, 1800, 1'b1);
        req_valid = 4'b0101;
        step(4'b0100, 2007, 1'b1);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_req_ready", {28'd0, req_ready}, 32'd0);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_id", {30'd0, rsp_id}, 32'd1);
            check("bp_rsp_sum", {20'd0, rsp_sum}, 32'd1800);
            check("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        step(4'b0001, 6, 1'b1);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Reset mid-flight: ptr=1 so grants 1 then 0, both discarded
        req_valid = 4'b0011;
        step(4'b0010, 0, 1'b0);
        req_valid = 4'b0001;
        step(4'b0001, 0, 1'b0);
        req_valid = 4'b0000;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        // ptr restarted at 0: 0 wins over 3
        req_valid = 4'b1001;
        step(4'b0001, 6, 1'b1);
        req_valid = 4'b0000;
        repeat (4) tick();

        // Idle: nothing moves, ptr stays at 1
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_valid", {31'd0, rsp_valid}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        req_valid = 4'b1111;
        step(4'b0010, 1800, 1'b1);
        req_valid = 4'b0000;
        repeat (4) tick();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
